// File: rtl/product_bcd_pkg.sv
// Shared definitions for the multiplier / binary-to-BCD converter pair:
// state encodings and default operand sizing.
package product_bcd_pkg;

    // Default multiplier operand width; the product is twice this wide.
    localparam int DEFAULT_WIDTH  = 4;
    // Enough BCD digits to hold the largest 2*DEFAULT_WIDTH-bit product.
    localparam int DEFAULT_DIGITS = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/product_bcd_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets 3 added,
// so that the following left shift carries correctly into the next digit.
module bcd_digit_adj (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/product_bcd.sv
// Sequential binary-to-BCD converter (double dabble) for a multiplier
// product. One bit is consumed per clock; the result register only
// changes when a conversion completes.
module product_bcd
    import product_bcd_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int DIGITS = DEFAULT_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [2*WIDTH-1:0]    in_data,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int PW = 2 * WIDTH;
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(PW + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(PW - 1);

    state_e         state_q, state_d;
    logic [BW-1:0]  scratch_q, scratch_d;
    logic [BW-1:0]  scratch_adj;
    logic [PW-1:0]  bin_q, bin_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [BW-1:0]  bcd_q, bcd_d;
    logic [BW+PW-1:0] shifted;

    // Per-digit "add 3 if >= 5" correction applied before every shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i (scratch_q[4*g +: 4]),
            .digit_o (scratch_adj[4*g +: 4])
        );
    end

    // Corrected scratch digits and remaining binary bits, shifted left by one.
    assign shifted = {scratch_adj[BW-2:0], bin_q, 1'b0};

    // Next-state and datapath control for the IDLE -> SHIFT -> DONE sequence.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned and no latch is inferred.
        state_d   = state_q;
        scratch_d = scratch_q;
        bin_d     = bin_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    bin_d     = in_data;
                    scratch_d = '0;
                    cnt_d     = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                {scratch_d, bin_d} = shifted;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_ITER) begin
                    bcd_d   = shifted[BW+PW-1:PW];
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            scratch_q <= '0;
            bin_q     <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
            state_q   <= state_d;
            scratch_q <= scratch_d;
            bin_q     <= bin_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);
    assign bcd  = bcd_q;

endmodule
